keypad_scanner: RTL and testbench

Scans a 4x4 matrix hex keypad, debounces each press and hands one decoded key code per press to mcu_io over a valid/ack handshake. It sits directly upstream of mcu_io's keyboard input. It owns the physical column drive and the row sampling, so mcu_io receives clean, single-event key codes instead of raw matrix levels.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_if.sv | 9 +
 rtl/keypad_row_sync.sv | 21 ++
 rtl/keypad_scanner.sv | 101 ++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, key map and row-priority helper for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    // Indexed {row, col}; entry 0 is row 0 / column 0.
    localparam logic [NUM_ROWS*NUM_COLS-1:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: key code valid/ack handshake between the scanner and its consumer
interface keypad_if;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       overrun;
    modport master (output key_code, key_valid, overrun, input key_ack);
    modport slave  (input key_code, key_valid, overrun, output key_ack);
endinterface

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the asynchronous row inputs, idles all-high
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad, debounces presses and publishes one key code per press
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Keypad_rows,
    output logic [3:0] Keypad_cols,
    keypad_if.master   kif
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    state_t          state, state_d;
    logic [CW-1:0]   win_cnt;
    logic [1:0]      col, col_d;
    logic [3:0]      rows_s, pat, pat_d;
    logic [DW-1:0]   cnt, cnt_d, inc;
    logic            win_end, publish, ack;
    logic [3:0]      hex;

    keypad_row_sync u_sync (.clk(clk), .rst(rst), .d(Keypad_rows), .q(rows_s));

    assign win_end     = win_cnt == CW'(SCAN_DIV - 1);
    assign inc         = cnt + DW'(1);
    assign ack         = kif.key_ack & kif.key_valid;
    assign hex         = KEY_MAP[{low_row(pat_d), col}];
    assign Keypad_cols = ~(4'b0001 << col);

    // One counter serves as match count in DEBOUNCE and release count in HELD.
    always_comb begin
        state_d = state;
        col_d   = col;
        pat_d   = pat;
        cnt_d   = cnt;
        publish = 1'b0;
        if (win_end) begin
            case (state)
                SCAN: begin
                    if (rows_s != 4'hF) begin
                        pat_d   = rows_s;
                        publish = DEBOUNCE_CNT == 1;
                        state_d = DEBOUNCE_CNT == 1 ? HELD : DEBOUNCE;
                        cnt_d   = DEBOUNCE_CNT == 1 ? '0 : DW'(1);
                    end else begin
                        col_d = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == pat) begin
                        publish = inc == DW'(DEBOUNCE_CNT);
                        state_d = publish ? HELD : DEBOUNCE;
                        cnt_d   = publish ? '0 : inc;
                    end else begin
                        state_d = SCAN;
                        col_d   = col + 2'd1;
                    end
                end
                HELD: begin
                    if (rows_s == 4'hF) begin
                        state_d = inc == DW'(DEBOUNCE_CNT) ? SCAN : HELD;
                        col_d   = inc == DW'(DEBOUNCE_CNT) ? col + 2'd1 : col;
                        cnt_d   = inc == DW'(DEBOUNCE_CNT) ? '0 : inc;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= SCAN;
            win_cnt       <= '0;
            col           <= '0;
            pat           <= 4'hF;
            cnt           <= '0;
            kif.key_code  <= 8'h00;
            kif.key_valid <= 1'b0;
            kif.overrun   <= 1'b0;
        end else begin
            state   <= state_d;
            win_cnt <= win_end ? '0 : win_cnt + CW'(1);
            col     <= col_d;
            pat     <= pat_d;
            cnt     <= cnt_d;
            // A same-clock ack frees the slot, so the new key loads without overrun.
            if (publish && (!kif.key_valid || ack))
                kif.key_code <= {4'h0, hex};
            kif.key_valid <= publish | (kif.key_valid & ~ack);
            kif.overrun   <= ack ? 1'b0 : kif.overrun | (publish & kif.key_valid);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized checks of keypad_scanner against a behavioural model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    bit         p_on = 1'b0;
    int         p_r = 0;
    int         p_c = 0;
    int         checks = 0;
    int         failures = 0;
    int         rises = 0;
    bit         pv = 1'b0;

    keypad_if kif();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .rst(rst), .Keypad_rows(rows), .Keypad_cols(cols), .kif(kif)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed key pulls its row low only while its column is driven.
    always_comb rows = (p_on && !cols[p_c]) ? ~(4'b0001 << p_r) : 4'hF;

    // Behavioural model: mode 0 scanning, 1 confirming, 2 waiting for release.
    int         kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};
    int         m_wc = 0, m_col = 0, m_mode = 0, m_mc = 0, m_rc = 0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_lat = 4'hF;
    logic [7:0] m_code = 8'h00;
    bit         m_valid = 1'b0, m_ovr = 1'b0;

    task automatic m_reset();
        m_wc = 0; m_col = 0; m_mode = 0; m_mc = 0; m_rc = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_lat = 4'hF;
        m_code = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic m_step();
        logic [3:0] rin, smp;
        bit pub, ack;
        int lr;
        pub = 1'b0;
        rin = (p_on && m_col == p_c) ? ~(4'b0001 << p_r) : 4'hF;
        if (m_wc == SD - 1) begin
            smp = m_s2;
            if (m_mode == 0) begin
                if (smp != 4'hF) begin
                    m_lat = smp;
                    m_mc = 1;
                    if (m_mc >= DB) begin pub = 1'b1; m_mode = 2; m_rc = 0; end
                    else m_mode = 1;
                end else m_col = (m_col + 1) % 4;
            end else if (m_mode == 1) begin
                if (smp == m_lat) begin
                    m_mc++;
                    if (m_mc >= DB) begin pub = 1'b1; m_mode = 2; m_rc = 0; end
                end else begin
                    m_mode = 0;
                    m_col = (m_col + 1) % 4;
                end
            end else begin
                if (smp == 4'hF) begin
                    m_rc++;
                    if (m_rc >= DB) begin m_mode = 0; m_col = (m_col + 1) % 4; end
                end else m_rc = 0;
            end
        end
        m_wc = (m_wc + 1) % SD;
        m_s2 = m_s1;
        m_s1 = rin;
        lr = 3;
        for (int r = 3; r >= 0; r--) if (!m_lat[r]) lr = r;
        ack = kif.key_ack && m_valid;
        if (pub && m_valid && !ack) m_ovr = 1'b1;
        else if (ack) m_ovr = 1'b0;
        if (pub && (!m_valid || ack)) begin
            m_code = 8'(kmap[lr][m_col]);
            m_valid = 1'b1;
        end else if (ack) m_valid = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) m_reset();
        else m_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        logic [3:0] mc;
        @(negedge clk);
        mc = ~(4'b0001 << m_col);
        chk("model_cols", cols, mc);
        chk("model_valid", kif.key_valid, m_valid);
        chk("model_code", kif.key_code, m_code);
        chk("model_overrun", kif.overrun, m_ovr);
        if (kif.key_valid && !pv) rises++;
        pv = kif.key_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int lim, output int took);
        took = 0;
        while (!kif.key_valid && took < lim) begin
            @(negedge clk);
            took++;
        end
        chk(nm, kif.key_valid, 1);
    endtask

    task automatic ack_pulse();
        kif.key_ack = 1'b1;
        @(negedge clk);
        kif.key_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int took, r0, n;
        logic [3:0] e, seen;
        bit bounce;
        kif.key_ack = 1'b0;
        cyc(3);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 8'h00);
        chk("rst_overrun", kif.overrun, 0);
        rst = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e = ~(4'b0001 << (((k + 1) / 4) % 4));
            chk("idle_cols", cols, e);
            chk("idle_valid", kif.key_valid, 0);
        end

        r0 = rises;
        p_r = 1; p_c = 1; p_on = 1'b1;
        wait_valid("press5_valid", 60, took);
        chk("press5_latency", took <= (4 + DB) * SD + 3 + 2, 1);
        chk("press5_code", kif.key_code, 8'h05);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k % 5 == 0) chk("press5_hold_cols", cols, 4'b1101);
        end
        chk("press5_once", rises - r0, 1);

        ack_pulse();
        chk("ack_clears", kif.key_valid, 0);
        ack_pulse();
        chk("ack_idle_valid", kif.key_valid, 0);
        chk("ack_idle_code", kif.key_code, 8'h05);

        p_on = 1'b0;
        n = 0;
        while (cols == 4'b1101 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("release_next_col", cols, 4'b1011);

        r0 = rises;
        p_r = 2; p_c = 2;
        for (int i = 0; i < 200; i++) begin
            p_on = ((i / 4) % 2) == 0;
            @(negedge clk);
        end
        p_on = 1'b0;
        cyc(10);
        seen = 4'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            seen = seen | ~cols;
        end
        chk("bounce_no_key", rises - r0, 0);
        chk("bounce_valid", kif.key_valid, 0);
        chk("bounce_scanning", seen, 4'hF);

        p_r = 0; p_c = 0; p_on = 1'b1;
        wait_valid("press1_valid", 60, took);
        chk("press1_code", kif.key_code, 8'h01);
        p_on = 1'b0;
        cyc(30);
        p_r = 3; p_c = 3; p_on = 1'b1;
        n = 0;
        while (!kif.overrun && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ovr_set", kif.overrun, 1);
        chk("ovr_code_kept", kif.key_code, 8'h01);
        chk("ovr_valid", kif.key_valid, 1);
        ack_pulse();
        chk("ovr_ack_valid", kif.key_valid, 0);
        chk("ovr_ack_cleared", kif.overrun, 0);
        p_on = 1'b0;
        cyc(30);

        p_r = 1; p_c = 1; p_on = 1'b1;
        n = 0;
        while (m_mode != 1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("reach_debounce", m_mode, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_cols", cols, 4'b1110);
        chk("midrst_valid", kif.key_valid, 0);
        chk("midrst_code", kif.key_code, 8'h00);
        chk("midrst_overrun", kif.overrun, 0);
        p_on = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(3);
        chk("restart_col0", cols, 4'b1110);
        cyc(1);
        chk("restart_col1", cols, 4'b1101);

        for (int it = 0; it < 40; it++) begin
            p_r = int'($urandom_range(0, 3));
            p_c = int'($urandom_range(0, 3));
            bounce = $urandom_range(0, 3) == 0;
            n = int'($urandom_range(5, 60));
            for (int j = 0; j < n; j++) begin
                p_on = bounce ? $urandom_range(0, 1) == 1 : 1'b1;
                kif.key_ack = $urandom_range(0, 5) == 0;
                @(negedge clk);
            end
            p_on = 1'b0;
            n = int'($urandom_range(5, 40));
            for (int j = 0; j < n; j++) begin
                kif.key_ack = $urandom_range(0, 5) == 0;
                @(negedge clk);
            end
        end
        kif.key_ack = 1'b0;
        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
